result_display: RTL and testbench
=================================

Name: result_display

Overview:
- Downstream consumer of the CPU's 32-bit `Result` bus; drives a multiplexed 7-segment display on the lab FPGA board.
- Captures `Result` into a shadow register under a valid strobe, with an optional freeze.
- Time-multiplexes the captured hex nibbles across the digits.
- Counts how many times the displayed value has changed.

Parameters:
- NUM_DIGITS, 8, number of physical digits scanned; legal values 4 or 8.
- REFRESH_DIV, 50000, clock cycles each digit stays enabled; minimum 2.
- ACTIVE_LOW, 1, when 1, `an` and `seg` are driven active-low.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- Result  input  32  CPU result bus
- result_valid  input  1  capture strobe; `Result` is sampled when high
- freeze  input  1  when high, the shadow register holds its value
- page  input  1  used only when NUM_DIGITS=4: 0 shows Result[15:0], 1 shows Result[31:16]; ignored when NUM_DIGITS=8
- an  output  NUM_DIGITS  digit enables, one-hot when active
- seg  output  7  segments, bit order {g,f,e,d,c,b,a}
- dp  output  1  decimal point; lit only on digit 0 while freeze=1
- change_cnt  output  8  number of shadow updates that changed the value; saturates at 255

Behaviour:
- Reset (rst=1 sampled at a clk edge):
  - shadow=0, change_cnt=0, refresh counter=0, digit index=0.
  - an, seg and dp all inactive: all ones if ACTIVE_LOW=1, else all zeros.
  - Reset applied mid-scan aborts the scan immediately; the first active digit after reset is digit 0.
- Capture:
  - If result_valid && !freeze, shadow <= Result at the edge.
  - freeze has priority over result_valid.
- Change count:
  - Increments when a capture loads a value different from the current shadow.
  - An equal-value capture does not increment.
  - At 255, the counter holds.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - At terminal count, the digit index increments, wrapping NUM_DIGITS-1 -> 0.
- Nibble select:
  - Digit i shows shadow[4*i+3 : 4*i].
  - For NUM_DIGITS=4, add a 16*page offset.
  - page is sampled every cycle; no latching.
- Decode: combinational hex decode (0-F), then registered outputs.
  - an, seg and dp are registered.
  - The new digit's `an` and `seg` appear together, one cycle after the digit index changes.
  - `an` is never multi-hot.
- Latency: a capture at edge N appears on the currently enabled digit's `seg` at edge N+1.
- The first active outputs after reset appear at edge 1 after rst deasserts, on digit 0.
- Simultaneous capture and digit advance: the new digit uses the new shadow value one cycle later. No glitch state is allowed.

Optional Feature:
- Macro: RESULT_DISPLAY_BLANK_EN.
- Defined: leading-zero blanking.
  - A digit whose nibble and all higher-order displayed nibbles are 0 has `seg` inactive.
  - Digit 0 is never blanked, so shadow=0 shows a single "0".
  - `an` still scans normally.
- Undefined: all digits are always decoded, including leading zeros.

Decomposition:
- Package `display_pkg`:
  - SEG_* constants for the 16 hex glyphs plus SEG_OFF.
  - Typedef `seg_t` (logic [6:0]).
  - Typedef `digit_idx_t` (logic [2:0]).
- Sub-module `hex7seg`: purely combinational 4-bit -> seg_t decode, instantiated once.
- All state stays in `result_display`.

Test Plan (sim with REFRESH_DIV=4, NUM_DIGITS=8, ACTIVE_LOW=1):
- Reset: rst high 2 cycles, then low -> an=8'hFF, seg=7'h7F, change_cnt=0 while rst=1; an=8'hFE at edge 1 after rst deasserts.
- Capture 32'h1234ABCD with one valid pulse, no freeze -> over 32 cycles an walks FE,FD,FB,...,7F; seg shows D,C,B,A,4,3,2,1; change_cnt=1.
- Same value captured again -> change_cnt stays 1.
- freeze=1 with valid Result=32'hFFFFFFFF -> shadow unchanged; dp=0 on digit 0 only.
- 300 distinct captures -> change_cnt saturates at 255.
- Reset asserted while digit 5 is active -> outputs inactive next edge; scan restarts at digit 0.
- With RESULT_DISPLAY_BLANK_EN, Result=32'h0000_00A0 -> digits 7..2 blank; digit 1 shows A, digit 0 shows 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and glyph constants for the result_display 7-segment driver.
// Glyphs are active-high in {g,f,e,d,c,b,a} order; polarity is applied at the outputs.
package display_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [2:0] digit_idx_t;

    localparam seg_t SEG_0   = 7'h3F;
    localparam seg_t SEG_1   = 7'h06;
    localparam seg_t SEG_2   = 7'h5B;
    localparam seg_t SEG_3   = 7'h4F;
    localparam seg_t SEG_4   = 7'h66;
    localparam seg_t SEG_5   = 7'h6D;
    localparam seg_t SEG_6   = 7'h7D;
    localparam seg_t SEG_7   = 7'h07;
    localparam seg_t SEG_8   = 7'h7F;
    localparam seg_t SEG_9   = 7'h6F;
    localparam seg_t SEG_A   = 7'h77;
    localparam seg_t SEG_B   = 7'h7C;
    localparam seg_t SEG_C   = 7'h39;
    localparam seg_t SEG_D   = 7'h5E;
    localparam seg_t SEG_E   = 7'h79;
    localparam seg_t SEG_F   = 7'h71;
    localparam seg_t SEG_OFF = 7'h00;

endpackage

// File: rtl/result_display_hex7seg.sv
// Purely combinational hex nibble to 7-segment glyph decoder (active-high glyphs).
module hex7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_OFF;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// Captures the CPU Result bus and scans its hex nibbles across a multiplexed 7-segment display.
// Optional leading-zero blanking is enabled by defining RESULT_DISPLAY_BLANK_EN.
module result_display
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           Result,
    input  logic                  result_valid,
    input  logic                  freeze,
    input  logic                  page,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [7:0]            change_cnt
);

    localparam int                 CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]   REFRESH_TC = CNT_W'(REFRESH_DIV - 1);
    localparam digit_idx_t         LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam seg_t               SEG_POL    = {7{ACTIVE_LOW}};

    logic [31:0]           shadow;
    logic [CNT_W-1:0]      refresh_cnt;
    digit_idx_t            digit_idx;
    logic                  capture;
    logic [31:0]           window;
    logic [3:0]            nibble;
    logic                  blank;
    seg_t                  glyph;
    seg_t                  seg_next;
    logic [NUM_DIGITS-1:0] an_onehot;

    assign capture = result_valid && !freeze;

    // Shadow register and saturating count of value-changing captures
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow     <= '0;
            change_cnt <= '0;
        end else if (capture) begin
            shadow <= Result;
            if (Result != shadow && change_cnt != 8'hFF) begin
                change_cnt <= change_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == REFRESH_TC) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == LAST_DIGIT) ? digit_idx_t'(0) : digit_idx + digit_idx_t'(1);
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    // The displayed window is the whole shadow, or the page-selected half on 4-digit boards
    always_comb begin
        window = shadow;
        if (NUM_DIGITS == 4) begin
            window = page ? {16'h0000, shadow[31:16]} : {16'h0000, shadow[15:0]};
        end
    end

    assign nibble    = window[{digit_idx, 2'b00} +: 4];
    assign an_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx;

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (glyph)
    );

`ifdef RESULT_DISPLAY_BLANK_EN
    assign blank = (digit_idx != digit_idx_t'(0)) && ((window >> {digit_idx, 2'b00}) == 32'h0);
`else
    assign blank = 1'b0;
`endif

    assign seg_next = blank ? SEG_OFF : glyph;

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_POL;
            seg <= SEG_POL;
            dp  <= ACTIVE_LOW;
        end else begin
            an  <= an_onehot ^ AN_POL;
            seg <= seg_next ^ SEG_POL;
            dp  <= ((digit_idx == digit_idx_t'(0)) && freeze) ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display (NUM_DIGITS=8, REFRESH_DIV=4, ACTIVE_LOW=1).
// Expected outputs come from an arithmetic model of scan position and captured value.
module tb_result_display;

    localparam int NUM_DIGITS  = 8;
    localparam int REFRESH_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Result = 32'h0;
    logic        result_valid = 1'b0;
    logic        freeze = 1'b0;
    logic        page = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  change_cnt;

    result_display #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Result       (Result),
        .result_valid (result_valid),
        .freeze       (freeze),
        .page         (page),
        .an           (an),
        .seg          (seg),
        .dp           (dp),
        .change_cnt   (change_cnt)
    );

    always #5 clk = ~clk;

    // Glyphs for 0..F, active-high {g,f,e,d,c,b,a}
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] m_shadow = 32'h0;
    int          m_cnt = 0;
    int          m_edges = 0;
    int          m_digit = 0;
    logic [7:0]  exp_an = 8'hFF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Drive one cycle of inputs and advance the model by that edge
    task automatic applyStimulus(input logic r, input logic v, input logic f,
                                 input logic [31:0] res, input logic pg);
        int nib;
        logic [31:0] higher;
        @(negedge clk);
        rst = r; result_valid = v; freeze = f; Result = res; page = pg;
        @(posedge clk);
        if (r) begin
            m_shadow = 32'h0;
            m_cnt    = 0;
            m_edges  = 0;
            m_digit  = -1;
            exp_an   = 8'hFF;
            exp_seg  = 7'h7F;
            exp_dp   = 1'b1;
        end else begin
            m_digit = (m_edges / REFRESH_DIV) % NUM_DIGITS;
            nib     = int'((m_shadow >> (4 * m_digit)) & 32'hF);
            higher  = m_shadow >> (4 * m_digit);
            exp_an  = ~(8'h01 << m_digit);
            exp_seg = ~glyph[nib];
`ifdef RESULT_DISPLAY_BLANK_EN
            if (m_digit != 0 && higher == 32'h0) exp_seg = 7'h7F;
`else
            if (higher == 32'hFFFF_FFFF && m_digit < 0) exp_seg = 7'h7F;
`endif
            exp_dp = !(m_digit == 0 && f);
            if (v && !f) begin
                if (res != m_shadow && m_cnt < 255) m_cnt++;
                m_shadow = res;
            end
            m_edges++;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".an"},  {24'h0, an},         {24'h0, exp_an});
        check({tag, ".seg"}, {25'h0, seg},        {25'h0, exp_seg});
        check({tag, ".dp"},  {31'h0, dp},         {31'h0, exp_dp});
        check({tag, ".cnt"}, {24'h0, change_cnt}, 32'(m_cnt));
    endtask

    initial begin
        logic [31:0] r32;
        bit          found;

        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("reset");
        end
        check("reset.an_const", {24'h0, an}, 32'h0000_00FF);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("first");
        check("first.an_fe", {24'h0, an}, 32'h0000_00FE);

        // Single capture then a full scan of all digits
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h1234_ABCD, 1'b0);
        checkOutput("cap");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'($urandom_range(0, 1)));
            checkOutput("scan");
        end
        check("scan.cnt_one", {24'h0, change_cnt}, 32'd1);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h1234_ABCD, 1'b0);
        checkOutput("same");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("same.cnt_one", {24'h0, change_cnt}, 32'd1);

        // Frozen capture attempts must be ignored
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
            checkOutput("freeze");
        end
        check("freeze.shadow", dut.shadow, 32'h1234_ABCD);

        // Many distinct captures drive the counter into saturation
        for (int i = 0; i < 300; i++) begin
            r32 = {$urandom} ^ 32'(i);
            applyStimulus(1'b0, 1'b1, 1'b0, r32, 1'b0);
            checkOutput("sat");
        end
        check("sat.cnt_255", {24'h0, change_cnt}, 32'd255);

        // Mixed random traffic, including repeats of the current value
        for (int i = 0; i < 150; i++) begin
            r32 = ($urandom_range(0, 3) == 0) ? m_shadow : $urandom;
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), r32,
                          1'($urandom_range(0, 1)));
            checkOutput("mix");
        end

        // Fresh reset, a few captures, then reset while digit 5 is being shown
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rst2");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0F1E_2D3C, 1'b0);
        checkOutput("rst2.cap");
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("seek5");
            if (m_digit == 5) found = 1'b1;
        end
        check("seek5.found", {31'h0, found}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("midrst");
        check("midrst.an_off", {24'h0, an}, 32'h0000_00FF);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("restart");
        check("restart.an_fe", {24'h0, an}, 32'h0000_00FE);

        // Small value exercising leading zeros
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_00A0, 1'b0);
        checkOutput("lz");
        for (int i = 0; i < 36; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("lz.scan");
        end

        $display("[TB] done");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
